spi_master_gen: RTL
===================

# spi_master_gen

Parametrised single-clock SPI master, the next generation of the team's fixed-length SPI master. All four SPI modes, runtime transfer length up to C bits, MSB- or LSB-first ordering, a programmable SPI clock divider, explicit slave-select lead and trail times, and a ready/valid handshake. It sits between sensor/DAC control logic and the off-chip SPI bus. Every output is registered in the CLK_IN domain; no logic is clocked from SPI_CLK.

## Interface
- N, 1: number of active-low slave-select lines.
- C, 32: maximum transfer length in bits, 2..1024.
- LEN_W, 6: width of `len`; must satisfy 2^LEN_W > C.
- DIV, 2: CLK_IN cycles per SPI_CLK half-period, ≥1.

- CLK_IN  in  1  system clock; every register uses its rising edge.
- RST  in  1  asynchronous, active-high reset.
- trigger  in  1  start request, sampled while `ready`=1.
- din  in  C  transmit word, right-aligned in din[len-1:0].
- len  in  LEN_W  bits to transfer; 0 or >C means C.
- target  in  N  slave-select mask; bit=1 asserts that SS line.
- CPOL, CPHA  in  1 each  SPI mode.
- LSB_FIRST  in  1  1 = shift bit 0 first.
- MISO  in  1  serial data in.
- MOSI  out  1  serial data out.
- SPI_CLK  out  1  serial clock.
- SPI_SS  out  N  active-low selects, ~target during a transfer.
- dout  out  C  received word, right-aligned, upper bits zero.
- ready  out  1  idle; trigger accepted.
- busy  out  1  transfer in progress (= ~ready).
- valid  out  1  one-cycle pulse when dout updates.

## Operation
- States: IDLE → LEAD → SHIFT → TRAIL → IDLE.
- IDLE: ready=1. trigger=1 latches din, effective len L, target, CPOL, CPHA and LSB_FIRST, then enters LEAD. Later changes to any of these inputs do not affect the transfer in progress.
- LEAD, DIV cycles: SS asserted, SPI_CLK=CPOL. In CPHA=0, MOSI already carries the first bit.
- SHIFT, 2·L·DIV cycles: SPI_CLK toggles every DIV cycles, giving 2L edges. Odd edges are leading, even edges trailing.
  - CPHA=0: sample MISO on leading edges; shift MOSI on trailing edges, except the last.
  - CPHA=1: drive MOSI on leading edges, the first bit on edge 1; sample MISO on trailing edges.
- TRAIL, DIV cycles: SPI_CLK=CPOL, SS still asserted, MOSI holds its last bit.
- End of TRAIL: SS released, dout loaded from the receive shifter, valid=1 for one cycle, then IDLE.
- Bit order:
  - MSB-first: transmit din[L-1] down to din[0]; the first received bit lands in dout[L-1].
  - LSB-first: transmit din[0] up to din[L-1]; the first received bit lands in dout[0].
- dout[C-1:L]=0. dout holds its value until the next valid.
- Bit counter and divider counter are internal and sized from C and DIV.

## Timing
- Reset values (asynchronous, immediate): SPI_SS all 1, MOSI=0, dout=0, valid=0, busy=0, ready=1, state IDLE.
  - While idle, SPI_CLK follows the live CPOL input.
  - RST mid-transfer aborts it: no valid pulse, SS released, SPI_CLK returns to CPOL at once.
- Trigger accepted at rising edge k; from that edge busy=1 and SS asserted.
- SPI_CLK edge i (1..2L) occurs at edge k+DIV·i.
- SS release, valid=1 and busy=0 all occur at edge k+DIV·(2L+2). Trigger-to-valid latency is DIV·(2L+2) cycles.
- A trigger held high during the valid cycle is accepted at the next edge. Back-to-back transfers therefore have a 1-cycle idle gap.
- trigger while busy is ignored, not queued.
- target=0 is legal: clocks run, no SS asserts, valid still pulses.
- SPI_CLK frequency = f(CLK_IN)/(2·DIV). MOSI changes only on CLK_IN edges coincident with SPI_CLK edges, or at k.

## Test plan
- N=2, DIV=2. Mode 0, len=8, din=0xA5, target=2'b01, MISO=MOSI loopback → SPI_SS=2'b10 during the transfer; 16 SPI_CLK edges; MOSI sequence 1,0,1,0,0,1,0,1; dout=0x000000A5; valid at k+36.
- Mode 3, len=0 (C=32), din=0xDEADBEEF, MISO tied to a slave model returning 0x12345678 → idle SPI_CLK=1; MISO sampled on rising edges; dout=0x12345678; valid at k+132.
- LSB_FIRST=1, mode 1, len=4, din=0x1, loopback → MOSI 1,0,0,0; dout=0x1.
- Mid-transfer: RST pulsed after edge 5 → SS=all 1, valid never pulses, dout=0, ready=1. A subsequent trigger completes normally.
- trigger held high continuously, din changed during the transfer → second trigger ignored while busy; the first transfer uses the original din; the next transfer starts 1 cycle after valid.
- DIV=1, len=2, mode 2 → SPI_CLK toggles every CLK_IN cycle; valid at k+6.

Source files
------------

// File: rtl/spi_master_gen.sv
// spi_master_gen
//   Single-clock SPI master: all four SPI modes, runtime transfer length up to
//   C bits, MSB- or LSB-first ordering, SPI clock divider, slave-select lead
//   and trail times, and a ready/valid handshake. Every register is clocked
//   by CLK_IN; nothing is clocked from SPI_CLK.
//
// Ports
//   CLK_IN, RST        system clock, asynchronous active-high reset
//   trigger            start request, accepted while ready=1
//   din, len           transmit word (right-aligned) and length (0 or >C -> C)
//   target             slave-select mask, 1 asserts the corresponding SS line
//   CPOL, CPHA         SPI mode
//   LSB_FIRST          1 = bit 0 is shifted first
//   MISO / MOSI        serial data in / out
//   SPI_CLK, SPI_SS    serial clock, active-low slave selects
//   dout, valid        received word (right-aligned) and its one-cycle strobe
//   ready, busy        idle / transfer in progress
module spi_master_gen #(
    parameter int N     = 1,
    parameter int C     = 32,
    parameter int LEN_W = 6,
    parameter int DIV   = 2
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             trigger,
    input  logic [C-1:0]     din,
    input  logic [LEN_W-1:0] len,
    input  logic [N-1:0]     target,
    input  logic             CPOL,
    input  logic             CPHA,
    input  logic             LSB_FIRST,
    input  logic             MISO,
    output logic             MOSI,
    output logic             SPI_CLK,
    output logic [N-1:0]     SPI_SS,
    output logic [C-1:0]     dout,
    output logic             ready,
    output logic             busy,
    output logic             valid
);

    // Tick counter spans 2L SPI edges plus the trail and release ticks.
    localparam int EW = $clog2(2 * C + 3);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic             lsb_q, lsb_d;
    logic             phase_q, phase_d;
    logic             mosi_q, mosi_d;
    logic [C-1:0]     tx_q, tx_d;
    logic [C-1:0]     rx_q, rx_d;
    logic [N-1:0]     ss_q, ss_d;
    logic [C-1:0]     dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [LEN_W-1:0] len_eff;
    logic [C-1:0]     aligned;
    logic             tick;
    logic [EW-1:0]    edge_nxt;
    logic [EW-1:0]    two_l;
    logic             spi_edge;
    logic             sample_now;
    logic             drive_now;

    assign len_eff  = (len == '0 || int'(len) > C) ? LEN_W'(C) : len;
    assign tick     = (div_q == DW'(DIV - 1));
    assign edge_nxt = edge_q + EW'(1);
    assign two_l    = EW'({len_q, 1'b0});
    // Ticks 1..2L are SPI_CLK edges; odd ticks are leading edges.
    assign spi_edge   = busy_q && tick && (edge_nxt <= two_l);
    assign sample_now = cpha_q ? ~edge_nxt[0] : edge_nxt[0];
    // CPHA=0 pre-loads the first bit at accept time, so its final trailing
    // edge has nothing left to shift out.
    assign drive_now  = cpha_q ? edge_nxt[0] : (~edge_nxt[0] && (edge_nxt != two_l));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        len_d   = len_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        phase_d = phase_q;
        mosi_d  = mosi_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ss_d    = ss_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        aligned = '0;

        if (state_q == IDLE) begin
            if (trigger) begin
                state_d = LEAD;
                busy_d  = 1'b1;
                ss_d    = ~target;
                len_d   = len_eff;
                cpol_d  = CPOL;
                cpha_d  = CPHA;
                lsb_d   = LSB_FIRST;
                div_d   = '0;
                edge_d  = '0;
                phase_d = 1'b0;
                rx_d    = '0;
                // MSB-first: move din[L-1] up to the top of the shifter.
                aligned = LSB_FIRST ? din : (din << (C - int'(len_eff)));
                if (!CPHA) begin
                    mosi_d = LSB_FIRST ? aligned[0] : aligned[C-1];
                    tx_d   = LSB_FIRST ? (aligned >> 1) : (aligned << 1);
                end else begin
                    tx_d   = aligned;
                end
            end
        end else begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) begin
                edge_d = edge_nxt;
            end
            if (spi_edge) begin
                phase_d = ~phase_q;
                if (sample_now) begin
                    rx_d = lsb_q ? {MISO, rx_q[C-1:1]} : {rx_q[C-2:0], MISO};
                end
                if (drive_now) begin
                    mosi_d = lsb_q ? tx_q[0] : tx_q[C-1];
                    tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                end
            end
            case (state_q)
                LEAD: begin
                    if (tick) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick && edge_nxt == two_l + EW'(1)) begin
                        state_d = TRAIL;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ss_d    = '1;
                        valid_d = 1'b1;
                        // LSB-first fills from the top; realign to bit 0.
                        dout_d  = lsb_q ? (rx_q >> (C - int'(len_q))) : rx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            len_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            phase_q <= 1'b0;
            mosi_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            ss_q    <= '1;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            len_q   <= len_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            phase_q <= phase_d;
            mosi_q  <= mosi_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ss_q    <= ss_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Idle clock level tracks the live CPOL input; during a transfer the
    // latched polarity is toggled by the edge phase.
    assign SPI_CLK = busy_q ? (cpol_q ^ phase_q) : CPOL;
    assign MOSI    = mosi_q;
    assign SPI_SS  = ss_q;
    assign dout    = dout_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign ready   = ~busy_q;

endmodule
